// File: rtl/rcc_reg_arbiter.sv
// Round-robin arbiter sharing one RCC register-access port between NUM_REQ requesters.
// Optional BUSY timeout is enabled by defining RCC_ARB_TIMEOUT_EN.
module rcc_reg_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      m_req,
    input  logic [4*NUM_REQ-1:0]    m_we,
    input  logic [29*NUM_REQ-1:0]   m_addr,
    input  logic [32*NUM_REQ-1:0]   m_wdata,
    output logic [NUM_REQ-1:0]      m_ack,
    output logic [1:0]              m_rsp,
    output logic [31:0]             m_rdata,
    output logic                    req,
    output logic [3:0]              we,
    output logic [28:0]             addr,
    output logic [31:0]             wdata,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rsp
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned SW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rcc_reg_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        winner_q, winner_d;
    logic                 req_q, req_d;
    logic [3:0]           we_q, we_d;
    logic [28:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   m_ack_q, m_ack_d;
    logic [1:0]           m_rsp_q, m_rsp_d;
    logic [31:0]          m_rdata_q, m_rdata_d;

`ifdef RCC_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
`endif

    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    logic                 grant_found;
    logic [IW-1:0]        grant_idx;
    logic [SW-1:0]        scan;
    logic [3:0]           sel_we;
    logic [28:0]          sel_addr;
    logic [31:0]          sel_wdata;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + SW'(i);
            if (scan >= SW'(NUM_REQ)) begin
                scan = scan - SW'(NUM_REQ);
            end
            if (!grant_found && m_req[scan[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IW-1:0];
            end
        end
        sel_we    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_we    = m_we[4*i +: 4];
                sel_addr  = m_addr[29*i +: 29];
                sel_wdata = m_wdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        winner_d  = winner_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        m_ack_d   = '0;
        m_rsp_d   = m_rsp_q;
        m_rdata_d = m_rdata_q;
`ifdef RCC_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    winner_d = grant_idx;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    req_d    = 1'b1;
                    state_d  = S_BUSY;
`ifdef RCC_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            S_BUSY: begin
                if (rsp != 2'b00) begin
                    req_d             = 1'b0;
                    m_rdata_d         = rdata;
                    m_rsp_d           = (rsp == 2'b01) ? 2'b01 : 2'b10;
                    m_ack_d[winner_q] = 1'b1;
                    state_d           = S_RESP;
                end
`ifdef RCC_ARB_TIMEOUT_EN
                // A real response in the expiry cycle takes precedence.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    req_d             = 1'b0;
                    m_rdata_d         = '0;
                    m_rsp_d           = 2'b10;
                    m_ack_d[winner_q] = 1'b1;
                    state_d           = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_RESP: begin
                rr_ptr_d = (winner_q == IW'(NUM_REQ - 1)) ? '0 : winner_q + IW'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            winner_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            m_ack_q   <= '0;
            m_rsp_q   <= '0;
            m_rdata_q <= '0;
`ifdef RCC_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            winner_q  <= winner_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            m_ack_q   <= m_ack_d;
            m_rsp_q   <= m_rsp_d;
            m_rdata_q <= m_rdata_d;
`ifdef RCC_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req     = req_q;
    assign we      = we_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign m_ack   = m_ack_q;
    assign m_rsp   = m_rsp_q;
    assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_rcc_reg_arbiter.sv
// Directed self-checking bench for rcc_reg_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_rcc_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [7:0]  m_we;
    logic [57:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_rsp;
    logic [31:0] m_rdata;
    logic        req;
    logic [3:0]  we;
    logic [28:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  rsp;

    int checks   = 0;
    int failures = 0;

    rcc_reg_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rsp   (m_rsp),
        .m_rdata (m_rdata),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rsp     (rsp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        rdata = '0; rsp = '0;
        tick();
        tick();
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_rsp", 64'(m_rsp), 64'd0);
        chk("rst_rdata", 64'(m_rdata), 64'd0);
        rst = 1'b0;

        // Single read from requester 0
        m_addr[28:0] = 29'h10; m_req = 2'b01;
        tick();
        chk("rd_req1", 64'(req), 64'd1);
        chk("rd_addr", 64'(addr), 64'h10);
        chk("rd_we", 64'(we), 64'd0);
        chk("rd_noack", 64'(m_ack), 64'd0);
        tick();
        chk("rd_req2", 64'(req), 64'd1);
        rsp = 2'b01; rdata = 32'hA5A5_0001;
        tick();
        chk("rd_reqlow", 64'(req), 64'd0);
        chk("rd_ack", 64'(m_ack), 64'b01);
        chk("rd_rsp", 64'(m_rsp), 64'b01);
        chk("rd_rdata", 64'(m_rdata), 64'hA5A5_0001);
        rsp = 2'b00; rdata = '0; m_req = 2'b00;
        tick();
        chk("rd_ackclr", 64'(m_ack), 64'd0);

        // Contention: grants alternate 0,1,0,1 from a fresh rr pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_addr[28:0] = 29'h100; m_addr[57:29] = 29'h200; m_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("ct_req", 64'(req), 64'd1);
            chk("ct_addr", 64'(addr), (t % 2 == 0) ? 64'h100 : 64'h200);
            rsp = 2'b01; rdata = 32'hC0 + 32'(t);
            tick();
            chk("ct_ack", 64'(m_ack), (t % 2 == 0) ? 64'b01 : 64'b10);
            chk("ct_rdata", 64'(m_rdata), 64'hC0 + 64'(t));
            rsp = 2'b00;
            tick();
            chk("ct_ackclr", 64'(m_ack), 64'd0);
        end
        m_req = 2'b00;

        // Error response to a write
        m_we[3:0] = 4'b0011; m_wdata[31:0] = 32'h1234_5678; m_addr[28:0] = 29'h20;
        m_req = 2'b01;
        tick();
        chk("er_req", 64'(req), 64'd1);
        chk("er_we", 64'(we), 64'b0011);
        chk("er_wdata", 64'(wdata), 64'h1234_5678);
        chk("er_addr", 64'(addr), 64'h20);
        rsp = 2'b11; rdata = 32'hDEAD_BEEF;
        tick();
        chk("er_ack", 64'(m_ack), 64'b01);
        chk("er_rsp", 64'(m_rsp), 64'b10);
        chk("er_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        chk("er_reqlow", 64'(req), 64'd0);
        rsp = 2'b00; m_req = 2'b00; m_we = '0; m_wdata = '0;
        tick();

        // Back-to-back from requester 0, address changed in the ack cycle
        m_addr[28:0] = 29'h4; m_req = 2'b01;
        tick();
        chk("bb_addr1", 64'(addr), 64'h4);
        rsp = 2'b01;
        tick();
        chk("bb_ack1", 64'(m_ack), 64'b01);
        m_addr[28:0] = 29'h8; rsp = 2'b00;
        tick();
        chk("bb_idle", 64'(req), 64'd0);
        tick();
        chk("bb_req2", 64'(req), 64'd1);
        chk("bb_addr2", 64'(addr), 64'h8);
        rsp = 2'b01;
        tick();
        chk("bb_ack2", 64'(m_ack), 64'b01);
        rsp = 2'b00; m_req = 2'b00;
        tick();

        // Reset while BUSY with requester 1 (rr pointer was 1 beforehand)
        m_addr[57:29] = 29'h30; m_req = 2'b10;
        tick();
        chk("rb_req", 64'(req), 64'd1);
        chk("rb_addr", 64'(addr), 64'h30);
        rst = 1'b1; m_req = 2'b00;
        tick();
        chk("rb_reqlow", 64'(req), 64'd0);
        chk("rb_noack", 64'(m_ack), 64'd0);
        chk("rb_addrclr", 64'(addr), 64'd0);
        rst = 1'b0;
        m_addr[28:0] = 29'h50; m_addr[57:29] = 29'h44; m_req = 2'b11;
        tick();
        chk("rb_ptr0", 64'(addr), 64'h50);
        rsp = 2'b01;
        tick();
        chk("rb_ack0", 64'(m_ack), 64'b01);
        m_req = 2'b10; rsp = 2'b00;
        tick();
        tick();
        chk("rb_req1", 64'(req), 64'd1);
        chk("rb_addr1", 64'(addr), 64'h44);
        rsp = 2'b01;
        tick();
        chk("rb_ack1", 64'(m_ack), 64'b10);
        rsp = 2'b00; m_req = 2'b00;
        tick();

        // Slave silent: timeout when enabled, otherwise indefinite wait
        m_addr[28:0] = 29'h60; m_req = 2'b01; rdata = 32'hFFFF_0000;
        tick();
        chk("to_req", 64'(req), 64'd1);
`ifdef RCC_ARB_TIMEOUT_EN
        repeat (7) begin
            tick();
            chk("to_hold", 64'(req), 64'd1);
        end
        tick();
        chk("to_reqlow", 64'(req), 64'd0);
        chk("to_ack", 64'(m_ack), 64'b01);
        chk("to_rsp", 64'(m_rsp), 64'b10);
        chk("to_rdata", 64'(m_rdata), 64'd0);
        tick();
        tick();
        chk("to_req2", 64'(req), 64'd1);
        repeat (7) tick();
        chk("to_edge_req", 64'(req), 64'd1);
        rsp = 2'b01; rdata = 32'h77;
        tick();
        chk("to_edge_ack", 64'(m_ack), 64'b01);
        chk("to_edge_rsp", 64'(m_rsp), 64'b01);
        chk("to_edge_rdata", 64'(m_rdata), 64'h77);
`else
        repeat (20) tick();
        chk("nt_hold", 64'(req), 64'd1);
        chk("nt_noack", 64'(m_ack), 64'd0);
        rsp = 2'b01; rdata = 32'h77;
        tick();
        chk("nt_ack", 64'(m_ack), 64'b01);
        chk("nt_rsp", 64'(m_rsp), 64'b01);
        chk("nt_rdata", 64'(m_rdata), 64'h77);
`endif
        rsp = 2'b00; m_req = 2'b00;
        tick();
        chk("end_idle", 64'(req), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
